div_result_bcd: RTL and testbench

//  Downstream stage of the 8-bit binary divider. Accepts a quotient/remainder

---
 rtl/div_result_bcd.sv | 126 ++++++++++++
 tb/tb_div_result_bcd.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/div_result_bcd.sv
// Converts a divider quotient/remainder pair to packed BCD using two parallel
// iterative double-dabble engines, with valid/ready handshakes on both sides.
module div_result_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      quotient,
    input  logic [WIDTH-1:0]      remainder,
    input  logic                  in_dbz,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd,
    output logic                  err,
    output logic                  busy
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   q_sh_q, q_sh_d, r_sh_q, r_sh_d;
    logic [SW-1:0]   q_step, r_step;
    logic [BW-1:0]   q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;
    logic            err_q, err_d, out_valid_q, out_valid_d;

    // Shift register layout is {bcd digits, binary}; adjust digits, then shift.
    function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] s);
        logic [SW-1:0] a;
        a = s;
        for (int d = 0; d < DIGITS; d++) begin
            if (a[WIDTH+4*d +: 4] >= 4'd5)
                a[WIDTH+4*d +: 4] = a[WIDTH+4*d +: 4] + 4'd3;
        end
        return {a[SW-2:0], 1'b0};
    endfunction

    assign q_step = dd_step(q_sh_q);
    assign r_step = dd_step(r_sh_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_sh_d      = q_sh_q;
        r_sh_d      = r_sh_q;
        q_bcd_d     = q_bcd_q;
        r_bcd_d     = r_bcd_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_dbz) begin
                        q_bcd_d     = '1;
                        r_bcd_d     = '1;
                        err_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        q_sh_d  = {{BW{1'b0}}, quotient};
                        r_sh_d  = {{BW{1'b0}}, remainder};
                        cnt_d   = '0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                q_sh_d = q_step;
                r_sh_d = r_step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    q_bcd_d     = q_step[SW-1 -: BW];
                    r_bcd_d     = r_step[SW-1 -: BW];
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            q_sh_q      <= '0;
            r_sh_q      <= '0;
            q_bcd_q     <= '0;
            r_bcd_q     <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_sh_q      <= q_sh_d;
            r_sh_q      <= r_sh_d;
            q_bcd_q     <= q_bcd_d;
            r_bcd_q     <= r_bcd_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign q_bcd     = q_bcd_q;
    assign r_bcd     = r_bcd_q;
    assign err       = err_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed plus randomized bench for div_result_bcd against an arithmetic BCD model.
`timescale 1ns/1ps
module tb_div_result_bcd;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [WIDTH-1:0] quotient = '0;
    logic [WIDTH-1:0] remainder = '0;
    logic            in_dbz = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BW-1:0]   q_bcd, r_bcd;
    logic            err, busy;

    int checks = 0;
    int failures = 0;
    int n_acc = 0, n_out = 0;
    int exp_acc = 0, exp_out = 0;

    div_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .quotient(quotient), .remainder(remainder), .in_dbz(in_dbz),
        .out_valid(out_valid), .out_ready(out_ready),
        .q_bcd(q_bcd), .r_bcd(r_bcd), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) n_acc <= n_acc + 1;
        if (!rst && out_valid && out_ready) n_out <= n_out + 1;
    end

    function automatic logic [BW-1:0] ref_bcd(input int v);
        logic [BW-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: idle gap, accept, latency, backpressure, release.
    task automatic run_op(input int q, input int r, input bit dbz, input int gap, input int hold);
        logic [BW-1:0] eq, er;
        int lat;
        eq = dbz ? {BW{1'b1}} : ref_bcd(q);
        er = dbz ? {BW{1'b1}} : ref_bcd(r);
        for (int g = 0; g < gap; g++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("idle_ready", in_ready, 1);
        in_valid = 1'b1; quotient = 8'(q); remainder = 8'(r); in_dbz = dbz;
        exp_acc++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        quotient = 8'($urandom); remainder = 8'($urandom); in_dbz = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, dbz ? 0 : WIDTH);
        check("q_bcd", q_bcd, eq);
        check("r_bcd", r_bcd, er);
        check("err", err, dbz);
        check("busy", busy, 1);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            quotient = 8'($urandom);
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_q", q_bcd, eq);
            check("hold_r", r_bcd, er);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp_out++;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
        check("keep_q", q_bcd, eq);
        check("keep_err", err, dbz);
    endtask

    initial begin
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_q", q_bcd, 0);
        check("rst_r", r_bcd, 0);
        check("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        run_op(28, 4, 1'b0, 0, 0);
        run_op(255, 0, 1'b0, 1, 0);
        run_op(0, 0, 1'b0, 0, 1);
        run_op(123, 45, 1'b1, 2, 0);
        run_op(99, 100, 1'b0, 0, 5);
        run_op(255, 255, 1'b0, 3, 2);

        // Reset in the middle of a conversion drops the operation.
        in_valid = 1'b1; quotient = 8'd200; remainder = 8'd7; in_dbz = 1'b0;
        exp_acc++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_q", q_bcd, 0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        run_op(200, 7, 1'b0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
        end
        @(posedge clk); #1;
        check("accept_count", n_acc, exp_acc);
        check("output_count", n_out, exp_out);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
